line_read_sched: RTL and testbench
==================================

// Module: line_read_sched
// PURPOSE
//   Sequences reads of the 2-port line buffer that feeds the Bayer-to-RGB binning stage.
//   Watches sensor CCD_FVAL/CCD_LVAL and counts written lines. After each completed line
//   it issues one read burst after a fixed gap, producing READ_EN, pixel index and line index.
//   Flags lines inside the valid window and reports read overruns.
// PARAMETERS
//   H_ACTIVE      640  pixels per read burst (READ_EN high cycles per line)
//   H_GAP         4    idle cycles between LVAL falling edge and burst start
//   VAL_LINE_MIN  2    oLINE_VALID only when line index > VAL_LINE_MIN
//   VAL_LINE_MAX  620  oLINE_VALID only when line index < VAL_LINE_MAX
// PORTS
//   CCD_PIXCLK    in   1   pixel clock; all logic on rising edge
//   RST_N         in   1   asynchronous active-low reset
//   CCD_FVAL      in   1   sensor frame valid
//   CCD_LVAL      in   1   sensor line valid (write side of line buffer)
//   iCLR_ERR      in   1   synchronous clear of oOVERRUN
//   oREAD_EN      out  1   line-buffer read request
//   oREAD_Cont    out  13  pixel index within burst, 0..H_ACTIVE-1
//   oV_Cont       out  13  index of line being read, 0 = first line of frame
//   oLINE_VALID   out  1   oREAD_EN && VAL_LINE_MIN < oV_Cont < VAL_LINE_MAX
//   oFRAME_START  out  1   one-cycle pulse on detected CCD_FVAL rising edge
//   oOVERRUN      out  1   sticky: a line completed while one was already pending
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, line counters 0, pending 0.
//   FVAL/LVAL registered once internally; edges detected on registered copies.
//   FSM states and transitions:
//     IDLE  -> ARMED on FVAL rise (pulse oFRAME_START, wr_line=0, oV_Cont=0).
//     ARMED -> GAP on LVAL fall (wr_line++).
//     GAP   -> READ after exactly H_GAP cycles.
//     READ  -> holds for H_ACTIVE cycles with oREAD_EN=1 and oREAD_Cont 0..H_ACTIVE-1.
//              On the last beat oV_Cont++, then: pending ? GAP (pending=0) : ARMED.
//   Latency: first oREAD_EN is H_GAP+2 cycles after the CCD_LVAL falling edge at the pin.
//   Pending: one-deep. An LVAL fall seen in GAP/READ sets pending.
//     LVAL fall with pending already 1: set oOVERRUN, drop that line, no counter wrap.
//   FVAL fall:
//     In ARMED or IDLE: go to IDLE.
//     In GAP/READ: finish the current burst and any pending burst, then go to IDLE.
//   FVAL rise while not IDLE (short blanking): restart at ARMED, abort any burst
//     (oREAD_EN=0 next cycle), clear pending, still pulse oFRAME_START.
//   oV_Cont saturates at 8191; oREAD_Cont returns to 0 after each burst.
//   oLINE_VALID is combinational from registered oREAD_EN/oV_Cont, so it is aligned with them.
//   iCLR_ERR and a new overrun in the same cycle: overrun wins (oOVERRUN=1).
//   Async reset mid-burst: outputs drop immediately.
//     Next burst only after a fresh FVAL rise, then LVAL fall.
// TESTING
//   1. Reset, FVAL rise, 3 lines LVAL high for 640 and low for 200 cycles ->
//      3 bursts of exactly 640 READ_EN cycles, oV_Cont 0,1,2, each starting H_GAP+2 after LVAL fall.
//   2. 625-line frame -> oLINE_VALID high only on bursts with oV_Cont 3..619; oFRAME_START one pulse.
//   3. LVAL blanking of 2 cycles (line ends mid-burst) -> burst completes, second burst after
//      H_GAP gap, oOVERRUN stays 0.
//   4. Three back-to-back line ends within one burst -> third line dropped, oOVERRUN=1
//      until iCLR_ERR pulse, then 0.
//   5. FVAL falls at burst beat 100 -> burst runs to beat 639, state IDLE, further LVAL ignored.
//   6. RST_N low at beat 300 -> oREAD_EN=0 asynchronously. After release, no burst until new
//      FVAL rise; then oV_Cont restarts at 0.

Source files
------------

// File: rtl/line_read_sched.sv
// Line-buffer read sequencer: after each sensor line ends, waits a fixed gap and then
// issues one read burst, tracking the line index and flagging overruns of the pending slot.
module line_read_sched #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_GAP        = 4,
    parameter int unsigned VAL_LINE_MIN = 2,
    parameter int unsigned VAL_LINE_MAX = 620
) (
    input  logic        CCD_PIXCLK,
    input  logic        RST_N,
    input  logic        CCD_FVAL,
    input  logic        CCD_LVAL,
    input  logic        iCLR_ERR,
    output logic        oREAD_EN,
    output logic [12:0] oREAD_Cont,
    output logic [12:0] oV_Cont,
    output logic        oLINE_VALID,
    output logic        oFRAME_START,
    output logic        oOVERRUN
);

    typedef enum logic [1:0] {StIdle, StArmed, StGap, StRead} state_e;

    state_e      state_q, state_d;
    logic        fval_r_q, fval_d1_q, lval_r_q, lval_d1_q;
    logic        read_en_q, read_en_d;
    logic [12:0] read_cnt_q, read_cnt_d;
    logic [12:0] v_cnt_q, v_cnt_d;
    logic [12:0] gap_cnt_q, gap_cnt_d;
    logic [12:0] wr_line_q, wr_line_d;
    logic        pending_q, pending_d;
    logic        frame_start_q, frame_start_d;
    logic        overrun_q, overrun_d;

    logic fval_rise, fval_fall, lval_fall, lval_take;
    logic last_beat, consume, ovr_set;

    function automatic logic [12:0] sat_inc(input logic [12:0] x);
        return (x == 13'h1fff) ? x : x + 13'd1;
    endfunction

    assign fval_rise = fval_r_q & ~fval_d1_q;
    assign fval_fall = ~fval_r_q & fval_d1_q;
    assign lval_fall = ~lval_r_q & lval_d1_q;
    // Line ends after the frame has closed are not scheduled.
    assign lval_take = lval_fall & fval_r_q;
    assign last_beat = (read_cnt_q == 13'(H_ACTIVE - 1));
    assign consume   = (state_q == StRead) && last_beat;

    always_comb begin
        state_d       = state_q;
        read_cnt_d    = read_cnt_q;
        v_cnt_d       = v_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        wr_line_d     = wr_line_q;
        pending_d     = pending_q;
        ovr_set       = 1'b0;
        frame_start_d = fval_rise;

        if (fval_rise) begin
            // Frame restart aborts whatever was in flight.
            state_d    = StArmed;
            read_cnt_d = '0;
            v_cnt_d    = '0;
            gap_cnt_d  = '0;
            wr_line_d  = '0;
            pending_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (fval_fall) begin
                        state_d = StIdle;
                    end else if (lval_take) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                        wr_line_d = sat_inc(wr_line_q);
                    end
                end
                StGap, StRead: begin
                    if (lval_take) begin
                        if (pending_q && !consume) begin
                            ovr_set = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                            wr_line_d = sat_inc(wr_line_q);
                        end
                    end
                    if (state_q == StGap) begin
                        if (gap_cnt_q == 13'(H_GAP - 1)) begin
                            state_d    = StRead;
                            read_cnt_d = '0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 13'd1;
                        end
                    end else if (last_beat) begin
                        read_cnt_d = '0;
                        gap_cnt_d  = '0;
                        v_cnt_d    = sat_inc(v_cnt_q);
                        if (pending_q || lval_take) begin
                            state_d   = StGap;
                            // A line ending on the last beat refills the slot being consumed.
                            pending_d = pending_q && lval_take;
                        end else begin
                            state_d = fval_r_q ? StArmed : StIdle;
                        end
                    end else begin
                        read_cnt_d = read_cnt_q + 13'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        read_en_d = (state_d == StRead);
        overrun_d = ovr_set ? 1'b1 : (iCLR_ERR ? 1'b0 : overrun_q);
    end

    always_ff @(posedge CCD_PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            // FVAL history starts high so a level held through reset is not a rise.
            fval_r_q      <= 1'b1;
            fval_d1_q     <= 1'b1;
            lval_r_q      <= 1'b0;
            lval_d1_q     <= 1'b0;
            state_q       <= StIdle;
            read_en_q     <= 1'b0;
            read_cnt_q    <= '0;
            v_cnt_q       <= '0;
            gap_cnt_q     <= '0;
            wr_line_q     <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            fval_r_q      <= CCD_FVAL;
            fval_d1_q     <= fval_r_q;
            lval_r_q      <= CCD_LVAL;
            lval_d1_q     <= lval_r_q;
            state_q       <= state_d;
            read_en_q     <= read_en_d;
            read_cnt_q    <= read_cnt_d;
            v_cnt_q       <= v_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            wr_line_q     <= wr_line_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

    assign oREAD_EN     = read_en_q;
    assign oREAD_Cont   = read_cnt_q;
    assign oV_Cont      = v_cnt_q;
    assign oFRAME_START = frame_start_q;
    assign oOVERRUN     = overrun_q;
    assign oLINE_VALID  = read_en_q && (v_cnt_q > 13'(VAL_LINE_MIN))
                          && (v_cnt_q < 13'(VAL_LINE_MAX));

endmodule

// File: tb/tb_line_read_sched.sv
// Bench for line_read_sched: event-level burst predictor plus scenario table and corner
// sequences; burst length is shortened so a full 625-line frame fits in a short run.
module tb_line_read_sched;

    localparam int HA   = 32;
    localparam int HG   = 4;
    localparam int VMIN = 2;
    localparam int VMAX = 620;

    logic        clk = 1'b0, rst_n = 1'b0, fval = 1'b0, lval = 1'b0, clr_err = 1'b0;
    logic        read_en, line_valid, frame_start, overrun;
    logic [12:0] read_cont, v_cont;

    line_read_sched #(
        .H_ACTIVE(HA), .H_GAP(HG), .VAL_LINE_MIN(VMIN), .VAL_LINE_MAX(VMAX)
    ) dut (
        .CCD_PIXCLK(clk), .RST_N(rst_n), .CCD_FVAL(fval), .CCD_LVAL(lval),
        .iCLR_ERR(clr_err), .oREAD_EN(read_en), .oREAD_Cont(read_cont), .oV_Cont(v_cont),
        .oLINE_VALID(line_valid), .oFRAME_START(frame_start), .oOVERRUN(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int start; int v; int len;} burst_t;
    typedef struct {
        string name; int nlines; int hi; int lo; int exp_bursts; int exp_valid; int exp_ovr;
    } frame_vec_t;

    int     n_cmp = 0, n_err = 0, cyc = 0;
    burst_t exp_q[$];
    burst_t cur;
    bit     in_burst = 0;
    int     beat, beat_errs;
    int     bursts_seen = 0, valid_seen = 0, fs_seen = 0, fs_cyc = 0;
    int     acc_q[$];
    bit     frame_open = 0;
    int     exp_ovr = 0, next_v = 0, model_bursts = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts burst start cycles from line-end times.
    // A line end detected at edge d is dropped when two accepted bursts are still unfinished.
    task automatic m_lval_fall(input int n);
        int d = n + 2;
        int cnt = 0;
        int s;
        if (!frame_open) return;
        foreach (acc_q[i]) if (acc_q[i] + HA > d) cnt++;
        if (cnt >= 2) begin
            exp_ovr = 1;
            return;
        end
        s = n + HG + 2;
        if (acc_q.size() > 0 && acc_q[$] + HA + HG > s) s = acc_q[$] + HA + HG;
        acc_q.push_back(s);
        exp_q.push_back('{start: s, v: next_v, len: HA});
        next_v++;
        model_bursts++;
    endtask

    task automatic m_fval_rise(input int n);
        burst_t kept[$];
        int cut = n + 2;
        if (in_burst && cut - cur.start < cur.len) cur.len = cut - cur.start;
        foreach (exp_q[i]) begin
            burst_t b;
            b = exp_q[i];
            if (b.start < cut) begin
                if (b.len > cut - b.start) b.len = cut - b.start;
                kept.push_back(b);
            end
        end
        exp_q = kept;
        acc_q.delete();
        next_v = 0;
        frame_open = 1;
    endtask

    task automatic m_reset();
        exp_q.delete();
        acc_q.delete();
        in_burst = 0;
        frame_open = 0;
        exp_ovr = 0;
        next_v = 0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (frame_start) begin
            fs_seen++;
            fs_cyc = cyc;
        end
        if (read_en) begin
            if (!in_burst) begin
                in_burst = 1; beat = 0; beat_errs = 0; bursts_seen++;
                if (line_valid) valid_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_burst", cyc, -1);
                    cur = '{start: cyc, v: -1, len: HA};
                end else begin
                    cur = exp_q.pop_front();
                    check("burst_start", cyc, cur.start);
                    check("burst_v", v_cont, cur.v);
                end
            end
            if (read_cont != 13'(beat)) beat_errs++;
            if (v_cont != 13'(cur.v)) beat_errs++;
            if (line_valid !== (cur.v > VMIN && cur.v < VMAX)) beat_errs++;
            beat++;
        end else if (in_burst) begin
            in_burst = 0;
            check("burst_len", beat, cur.len);
            check("burst_beat_errs", beat_errs, 0);
        end
    end

    task automatic fval_up();
        fval = 1'b1;
        m_fval_rise(cyc);
    endtask

    task automatic fval_down();
        fval = 1'b0;
        frame_open = 0;
    endtask

    task automatic line(input int hi, input int lo);
        lval = 1'b1;
        repeat (hi) @(negedge clk);
        lval = 1'b0;
        m_lval_fall(cyc);
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || in_burst) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_in_time"}, k < 4000, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_read(input string name);
        int k = 0;
        while (!read_en && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_read_seen"}, read_en, 1);
    endtask

    task automatic clear_err(input string name);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        check({name, "_ovr_cleared"}, overrun, 0);
        exp_ovr = 0;
    endtask

    task automatic run_frame(input frame_vec_t fv, output int bursts, output int valids,
                             output int fs_cnt, output int fs_at);
        int bs0 = bursts_seen;
        int vs0 = valid_seen;
        int fs0 = fs_seen;
        int rn;
        rn = cyc;
        fval_up();
        repeat (3) @(negedge clk);
        for (int i = 0; i < fv.nlines; i++) line(fv.hi, fv.lo);
        fval_down();
        drain(fv.name);
        bursts = bursts_seen - bs0;
        valids = valid_seen - vs0;
        fs_cnt = fs_seen - fs0;
        fs_at  = fs_cyc - rn;
    endtask

    frame_vec_t vecs[5];

    initial begin
        int b, v, f, fa, bs0, fs0, mb0;
        frame_vec_t rv;

        vecs[0] = '{name: "three_lines", nlines: 3, hi: HA, lo: 10,
                    exp_bursts: 3, exp_valid: 0, exp_ovr: 0};
        vecs[1] = '{name: "short_blank", nlines: 3, hi: HA, lo: 2,
                    exp_bursts: 3, exp_valid: 0, exp_ovr: 0};
        vecs[2] = '{name: "triple_end", nlines: 3, hi: 2, lo: 2,
                    exp_bursts: 2, exp_valid: 0, exp_ovr: 1};
        vecs[3] = '{name: "six_lines", nlines: 6, hi: HA, lo: 10,
                    exp_bursts: 6, exp_valid: 3, exp_ovr: 0};
        vecs[4] = '{name: "full_frame", nlines: 625, hi: HA, lo: 10,
                    exp_bursts: 625, exp_valid: 617, exp_ovr: 0};

        repeat (3) @(negedge clk);
        check("rst_read_en", read_en, 0);
        check("rst_read_cont", read_cont, 0);
        check("rst_v_cont", v_cont, 0);
        check("rst_line_valid", line_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_read_en", read_en, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i], b, v, f, fa);
            check({vecs[i].name, "_bursts"}, b, vecs[i].exp_bursts);
            check({vecs[i].name, "_valid_bursts"}, v, vecs[i].exp_valid);
            check({vecs[i].name, "_frame_starts"}, f, 1);
            check({vecs[i].name, "_frame_start_cycle"}, fa, 2);
            check({vecs[i].name, "_overrun"}, overrun, vecs[i].exp_ovr);
            clear_err(vecs[i].name);
        end

        // FVAL falls mid-burst: burst completes, later lines are ignored.
        bs0 = bursts_seen;
        fval_up();
        repeat (3) @(negedge clk);
        line(HA, 2);
        wait_read("fval_fall");
        repeat (10) @(negedge clk);
        fval_down();
        line(5, 5);
        drain("fval_fall");
        line(5, 5);
        line(5, 5);
        repeat (60) @(negedge clk);
        check("fval_fall_bursts", bursts_seen - bs0, 1);
        check("fval_fall_idle_read_en", read_en, 0);

        // Short blanking: FVAL re-rises mid-burst and aborts it.
        fs0 = fs_seen;
        fval_up();
        repeat (3) @(negedge clk);
        line(HA, 5);
        wait_read("abort");
        repeat (8) @(negedge clk);
        fval_down();
        @(negedge clk);
        fval_up();
        repeat (3) @(negedge clk);
        check("abort_read_en", read_en, 0);
        check("abort_v_cont", v_cont, 0);
        check("abort_read_cont", read_cont, 0);
        line(HA, 10);
        fval_down();
        drain("abort");
        check("abort_frame_starts", fs_seen - fs0, 2);

        // Asynchronous reset mid-burst with FVAL held high.
        fval_up();
        repeat (3) @(negedge clk);
        line(HA, 5);
        wait_read("reset");
        repeat (12) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_read_en", read_en, 0);
        check("async_rst_v_cont", v_cont, 0);
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bs0 = bursts_seen;
        fs0 = fs_seen;
        line(5, 5);
        line(5, 5);
        repeat (40) @(negedge clk);
        check("post_rst_no_burst", bursts_seen - bs0, 0);
        check("post_rst_no_frame_start", fs_seen - fs0, 0);
        fval_down();
        repeat (2) @(negedge clk);
        fval_up();
        repeat (3) @(negedge clk);
        line(HA, 10);
        fval_down();
        drain("post_rst");
        check("post_rst_bursts", bursts_seen - bs0, 1);

        // Randomized frames against the model.
        for (int r = 0; r < 8; r++) begin
            rv = '{name: "random", nlines: int'($urandom_range(2, 9)),
                   hi: int'($urandom_range(1, 40)), lo: int'($urandom_range(1, 40)),
                   exp_bursts: 0, exp_valid: 0, exp_ovr: 0};
            mb0 = model_bursts;
            run_frame(rv, b, v, f, fa);
            check("random_bursts", b, model_bursts - mb0);
            check("random_overrun", overrun, exp_ovr);
            clear_err("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
